// File: rtl/pipe_pkg.sv
// Shared types and default sizes for the fetch/decode pipeline register stage.
package pipe_pkg;
  localparam int DATA_W_DEF = 96;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;
endpackage

// File: rtl/pipe_stage_sat_counter.sv
// Saturating up-counter: adds i_amt when i_en, clamps at all-ones.
module sat_counter #(
  parameter int CNT_W = 16,
  parameter int AMT_W = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             i_en,
  input  logic [AMT_W-1:0] i_amt,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W+AMT_W-1:0] w_sum;

  // Extra headroom bits make any carry out of CNT_W visible as overflow.
  assign w_sum = {{AMT_W{1'b0}}, r_cnt} + {{CNT_W{1'b0}}, i_amt};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                 r_cnt <= '0;
    else if (i_en) begin
      if (|w_sum[CNT_W+AMT_W-1:CNT_W]) r_cnt <= '1;
      else                             r_cnt <= w_sum[CNT_W-1:0];
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with optional skid entry, hold, flush and drop count.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              hold,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);
  state_e            r_state, w_nxt;
  logic [DATA_W-1:0] r_main, w_skid;
  logic              w_acc, w_deq, w_ld_main, w_from_skid, w_ld_skid;
  logic [1:0]        w_drop_amt;

  assign w_acc     = in_valid & in_ready & ~flush;
  assign w_deq     = out_valid & out_ready & ~flush;
  assign out_valid = (r_state != EMPTY) & ~hold;
  assign out_data  = r_main;

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    w_nxt       = r_state;
    w_ld_main   = 1'b0;
    w_from_skid = 1'b0;
    w_ld_skid   = 1'b0;
    case (r_state)
      EMPTY: if (w_acc) begin
        w_ld_main = 1'b1;
        w_nxt     = ONE;
      end
      ONE: begin
        if (w_acc && !w_deq) begin
          w_ld_skid = 1'b1;
          w_nxt     = TWO;
        end else if (w_deq && !w_acc) begin
          w_nxt = EMPTY;
        end else if (w_acc && w_deq) begin
          w_ld_main = 1'b1;
        end
      end
      TWO: if (w_deq) begin
        w_ld_main   = 1'b1;
        w_from_skid = 1'b1;
        w_nxt       = ONE;
      end
      default: w_nxt = EMPTY;
    endcase
    if (flush) w_nxt = EMPTY;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= EMPTY;
      r_main  <= '0;
    end else begin
      r_state <= w_nxt;
      if (flush)          r_main <= '0;
      else if (w_ld_main) r_main <= w_from_skid ? w_skid : in_data;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] r_skid;
      logic              r_in_ready;
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_skid     <= '0;
          r_in_ready <= 1'b1;
        end else begin
          if (flush)          r_skid <= '0;
          else if (w_ld_skid) r_skid <= in_data;
          // Registered ready: computed from the next state so it breaks the ready path.
          r_in_ready <= (w_nxt != TWO);
        end
      end
      assign w_skid   = r_skid;
      assign in_ready = r_in_ready;
    end else begin : g_noskid
      assign w_skid   = '0;
      assign in_ready = (r_state == EMPTY) | (out_ready & ~hold);
    end
  endgenerate

  assign w_drop_amt = occupancy + {1'b0, in_valid & in_ready};

  sat_counter #(.CNT_W(CNT_W), .AMT_W(2)) u_drop_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .i_en    (flush),
    .i_amt   (w_drop_amt),
    .o_cnt   (drop_cnt)
  );
endmodule
